// File: rtl/fifo_stream_checker.sv
// Read-side soak agent: throttled reads from a FIFO, each word checked against a
// regenerated sequence (increment or 16-bit LFSR), with error count and first-mismatch capture.
//
// state | meaning
// IDLE  | waiting for start_i after reset
// RUN   | issuing reads, throttled by the rate LFSR, until len reads are issued
// DRAIN | one cycle for the data of the last read to arrive and be checked
// DONE  | results valid, done_o high; start_i begins a new run
module fifo_stream_checker #(
    parameter int         DW         = 16,
    parameter int         CNT_W      = 32,
    parameter int         PATTERN    = 0,
    parameter logic [7:0] LFSR8_SEED = 8'hA5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] len_i,
    input  logic [DW-1:0]    seed_i,
    input  logic [7:0]       rate_i,
    output logic             rd_en_o,
    input  logic [DW-1:0]    rd_data_i,
    input  logic             empty_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic [CNT_W-1:0] rcv_cnt_o,
    output logic [DW-1:0]    first_err_exp_o,
    output logic [DW-1:0]    first_err_got_o
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state, state_nxt;
    logic [7:0]       lfsr8, rate_q;
    logic [CNT_W-1:0] len_q, issued, rcv_cnt, err_cnt;
    logic [DW-1:0]    exp_inc, first_exp, first_got, exp_word, lfsr_word;
    logic [15:0]      exp_lfsr, seed16;
    logic             chk, err, can_read, fire, start_run, mismatch;

    // The LFSR sequence is 16 bits wide regardless of DW; resize on the way in and out.
    if (DW > 16) begin : g_wide
        assign seed16    = seed_i[15:0];
        assign lfsr_word = {{(DW-16){1'b0}}, exp_lfsr};
    end else if (DW == 16) begin : g_exact
        assign seed16    = seed_i;
        assign lfsr_word = exp_lfsr;
    end else begin : g_narrow
        assign seed16    = {{(16-DW){1'b0}}, seed_i};
        assign lfsr_word = exp_lfsr[DW-1:0];
    end

    assign exp_word  = (PATTERN == 1) ? lfsr_word : exp_inc;
    assign can_read  = !empty_i && (lfsr8 <= rate_q) && (issued < len_q);
    assign fire      = (state == RUN) && can_read;
    assign start_run = start_i && ((state == IDLE) || (state == DONE));
    assign mismatch  = chk && (rd_data_i != exp_word);

    always_comb begin
        state_nxt = state;
        rd_en_o   = 1'b0;
        busy_o    = 1'b0;
        done_o    = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) state_nxt = (len_i == '0) ? DONE : RUN;
            end
            RUN: begin
                busy_o  = 1'b1;
                rd_en_o = fire;
                if (fire && (issued == len_q - CNT_W'(1))) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy_o    = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                done_o = 1'b1;
                if (start_i) state_nxt = (len_i == '0) ? DONE : RUN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            lfsr8 <= LFSR8_SEED;
        end else begin
            state <= state_nxt;
            // Taps 8,6,5,4: maximal length, so a non-zero seed never reaches 0.
            if (state == RUN) lfsr8 <= {lfsr8[6:0], lfsr8[7] ^ lfsr8[5] ^ lfsr8[4] ^ lfsr8[3]};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            len_q  <= '0;
            rate_q <= '0;
            issued <= '0;
            chk    <= 1'b0;
        end else begin
            chk <= fire;
            if (start_run) begin
                len_q  <= len_i;
                rate_q <= rate_i;
                issued <= '0;
            end else if (fire) begin
                issued <= issued + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rcv_cnt   <= '0;
            err_cnt   <= '0;
            err       <= 1'b0;
            first_exp <= '0;
            first_got <= '0;
            exp_inc   <= '0;
            exp_lfsr  <= '0;
        end else if (start_run) begin
            rcv_cnt   <= '0;
            err_cnt   <= '0;
            err       <= 1'b0;
            first_exp <= '0;
            first_got <= '0;
            exp_inc   <= seed_i;
            exp_lfsr  <= seed16;
        end else if (chk) begin
            rcv_cnt  <= rcv_cnt + CNT_W'(1);
            exp_inc  <= exp_inc + DW'(1);
            exp_lfsr <= {exp_lfsr[14:0], exp_lfsr[15] ^ exp_lfsr[13] ^ exp_lfsr[12] ^ exp_lfsr[10]};
            if (mismatch) begin
                err <= 1'b1;
                if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
                if (!err) begin
                    first_exp <= exp_word;
                    first_got <= rd_data_i;
                end
            end
        end
    end

    assign err_o           = err;
    assign err_cnt_o       = err_cnt;
    assign rcv_cnt_o       = rcv_cnt;
    assign first_err_exp_o = first_exp;
    assign first_err_got_o = first_got;

endmodule

// File: tb/tb_fifo_stream_checker.sv
// Bench for fifo_stream_checker: an array-backed FIFO feeds the checker; results are
// compared against constant vectors and a word-index reference model.
module tb_fifo_stream_checker;
    localparam int DW    = 16;
    localparam int CNT_W = 32;

    logic             clk   = 1'b0;
    logic             rst   = 1'b1;
    logic             start = 1'b0;
    logic [CNT_W-1:0] len   = '0;
    logic [DW-1:0]    seed  = '0;
    logic [7:0]       rate  = '0;
    logic [DW-1:0]    rd_data = '0;
    logic             rd_en, empty, busy, done, err;
    logic [CNT_W-1:0] err_cnt, rcv_cnt;
    logic [DW-1:0]    first_exp, first_got;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] mem [0:4095];
    int   wr_ptr = 0;
    int   rd_ptr = 0;
    int   bad_reads = 0;
    logic hold_empty = 1'b0;
    logic flush = 1'b0;

    assign empty = (rd_ptr == wr_ptr) || hold_empty;

    always #5 clk = ~clk;

    fifo_stream_checker #(.DW(DW), .CNT_W(CNT_W), .PATTERN(0), .LFSR8_SEED(8'hA5)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .len_i(len), .seed_i(seed), .rate_i(rate),
        .rd_en_o(rd_en), .rd_data_i(rd_data), .empty_i(empty), .busy_o(busy), .done_o(done),
        .err_o(err), .err_cnt_o(err_cnt), .rcv_cnt_o(rcv_cnt),
        .first_err_exp_o(first_exp), .first_err_got_o(first_got)
    );

    // FIFO model: data appears the cycle after the read strobe
    always @(posedge clk) begin
        if (rd_en && empty) bad_reads <= bad_reads + 1;
        if (flush) rd_ptr <= wr_ptr;
        else if (rd_en) begin
            rd_data <= mem[rd_ptr % 4096];
            rd_ptr  <= rd_ptr + 1;
        end
    end

    typedef struct {
        int          vlen;
        logic [15:0] vseed;
        logic [7:0]  vrate;
        int          bad_idx;
        logic [15:0] bad_val;
        int          exp_rcv;
        int          exp_errs;
        logic        exp_err;
        logic [15:0] exp_fexp;
        logic [15:0] exp_fgot;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] w);
        mem[wr_ptr % 4096] = w;
        wr_ptr++;
    endtask

    task automatic do_run(input int l, input logic [DW-1:0] s, input logic [7:0] r, input int budget,
                          output int nrd, output int first_rd, output int last_rd, output int done_at);
        bit timed_out;
        @(negedge clk);
        start = 1'b1; len = CNT_W'(l); seed = s; rate = r;
        @(negedge clk);
        start = 1'b0;
        #1;
        nrd = 0; first_rd = -1; last_rd = -1; done_at = -1; timed_out = 1'b1;
        for (int c = 0; c < budget; c++) begin
            if (done) begin
                done_at = c;
                timed_out = 1'b0;
                break;
            end
            if (rd_en) begin
                nrd++;
                if (first_rd < 0) first_rd = c;
                last_rd = c;
            end
            @(negedge clk);
            #1;
        end
        check("run_completes", 64'(timed_out), 64'd0);
    endtask

    // Reference: word i of a run is expected to equal seed + i modulo 2^DW
    function automatic void model(input logic [DW-1:0] words[$], input logic [DW-1:0] s,
                                  output int rcv, output int errs,
                                  output logic [DW-1:0] fe, output logic [DW-1:0] fg);
        logic [DW-1:0] e;
        rcv = words.size(); errs = 0; fe = '0; fg = '0;
        for (int i = 0; i < words.size(); i++) begin
            e = s + DW'(i);
            if (words[i] != e) begin
                if (errs == 0) begin
                    fe = e;
                    fg = words[i];
                end
                errs++;
            end
        end
    endfunction

    initial begin
        int nrd, first_rd, last_rd, done_at, rcv_m, errs_m, n0;
        logic [DW-1:0] fe_m, fg_m, w;
        logic [DW-1:0] words[$];

        vecs[0] = '{8,  16'h0010, 8'd255, -1, 16'h0000, 8, 0, 1'b0, 16'h0000, 16'h0000};
        vecs[1] = '{8,  16'h0010, 8'd255,  3, 16'hBEEF, 8, 1, 1'b1, 16'h0013, 16'hBEEF};
        vecs[2] = '{3,  16'hFFFE, 8'd255, -1, 16'h0000, 3, 0, 1'b0, 16'h0000, 16'h0000};
        vecs[3] = '{0,  16'h1234, 8'd255, -1, 16'h0000, 0, 0, 1'b0, 16'h0000, 16'h0000};
        vecs[4] = '{3,  16'hFFFE, 8'd255,  2, 16'h0001, 3, 1, 1'b1, 16'h0000, 16'h0001};
        vecs[5] = '{5,  16'h7F00, 8'd255,  0, 16'h0000, 5, 1, 1'b1, 16'h7F00, 16'h0000};

        repeat (3) @(negedge clk);
        #1;
        check("reset_rd_en", 64'(rd_en), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_err", 64'(err), 64'd0);
        check("reset_err_cnt", 64'(err_cnt), 64'd0);
        check("reset_rcv_cnt", 64'(rcv_cnt), 64'd0);
        check("reset_first", 64'({first_exp, first_got}), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[k]) begin
            for (int i = 0; i < vecs[k].vlen; i++) begin
                w = vecs[k].vseed + DW'(i);
                if (i == vecs[k].bad_idx) w = vecs[k].bad_val;
                push(w);
            end
            do_run(vecs[k].vlen, vecs[k].vseed, vecs[k].vrate, 200, nrd, first_rd, last_rd, done_at);
            check($sformatf("vec%0d_reads", k), 64'(nrd), 64'(vecs[k].vlen));
            check($sformatf("vec%0d_rcv_cnt", k), 64'(rcv_cnt), 64'(vecs[k].exp_rcv));
            check($sformatf("vec%0d_err_cnt", k), 64'(err_cnt), 64'(vecs[k].exp_errs));
            check($sformatf("vec%0d_err", k), 64'(err), 64'(vecs[k].exp_err));
            check($sformatf("vec%0d_first_exp", k), 64'(first_exp), 64'(vecs[k].exp_fexp));
            check($sformatf("vec%0d_first_got", k), 64'(first_got), 64'(vecs[k].exp_fgot));
            check($sformatf("vec%0d_busy", k), 64'(busy), 64'd0);
            if (vecs[k].vlen == 0) begin
                check($sformatf("vec%0d_done_latency", k), 64'(done_at), 64'd0);
            end else begin
                check($sformatf("vec%0d_first_read", k), 64'(first_rd), 64'd0);
                check($sformatf("vec%0d_back_to_back", k), 64'(last_rd - first_rd), 64'(vecs[k].vlen - 1));
                check($sformatf("vec%0d_drain_to_done", k), 64'(done_at - last_rd), 64'd2);
            end
        end

        // Empty for 5 cycles mid-run
        for (int i = 0; i < 12; i++) push(16'h0400 + 16'(i));
        fork
            begin
                repeat (3) @(negedge clk);
                hold_empty = 1'b1;
                for (int i = 0; i < 5; i++) begin
                    #1;
                    check("gap_rd_en_low", 64'(rd_en), 64'd0);
                    @(negedge clk);
                end
                hold_empty = 1'b0;
            end
        join_none
        do_run(12, 16'h0400, 8'd255, 200, nrd, first_rd, last_rd, done_at);
        check("gap_reads", 64'(nrd), 64'd12);
        check("gap_rcv_cnt", 64'(rcv_cnt), 64'd12);
        check("gap_err_cnt", 64'(err_cnt), 64'd0);
        check("gap_stalled", 64'(last_rd - first_rd > 11), 64'd1);

        // Randomized runs against the reference model
        for (int k = 0; k < 12; k++) begin
            int l;
            logic [DW-1:0] s;
            logic [7:0] r;
            l = $urandom_range(40, 1);
            s = DW'($urandom);
            r = 8'($urandom_range(255, 64));
            words.delete();
            for (int i = 0; i < l; i++) begin
                w = ($urandom_range(4, 0) == 0) ? DW'($urandom) : s + DW'(i);
                words.push_back(w);
                push(w);
            end
            model(words, s, rcv_m, errs_m, fe_m, fg_m);
            do_run(l, s, r, 2000, nrd, first_rd, last_rd, done_at);
            check($sformatf("rnd%0d_reads", k), 64'(nrd), 64'(l));
            check($sformatf("rnd%0d_rcv_cnt", k), 64'(rcv_cnt), 64'(rcv_m));
            check($sformatf("rnd%0d_err_cnt", k), 64'(err_cnt), 64'(errs_m));
            check($sformatf("rnd%0d_err", k), 64'(err), 64'(errs_m != 0));
            check($sformatf("rnd%0d_first_exp", k), 64'(first_exp), 64'(fe_m));
            check($sformatf("rnd%0d_first_got", k), 64'(first_got), 64'(fg_m));
        end

        // rate 127 over 1000 words: roughly half the RUN cycles read
        for (int i = 0; i < 1000; i++) push(16'h2000 + 16'(i));
        do_run(1000, 16'h2000, 8'd127, 4000, nrd, first_rd, last_rd, done_at);
        check("r127_reads", 64'(nrd), 64'd1000);
        check("r127_rcv_cnt", 64'(rcv_cnt), 64'd1000);
        check("r127_err", 64'({err, err_cnt}), 64'd0);
        check("r127_duty_40_60", 64'((nrd * 100 >= 40 * (done_at - 1)) && (nrd * 100 <= 60 * (done_at - 1))), 64'd1);

        // rate 0 never reads; a start during RUN is ignored
        for (int i = 0; i < 4; i++) push(16'h3000 + 16'(i));
        @(negedge clk);
        start = 1'b1; len = 4; seed = 16'h3000; rate = 8'd0;
        @(negedge clk);
        start = 1'b0;
        n0 = 0;
        for (int c = 0; c < 1000; c++) begin
            #1;
            if (rd_en) n0++;
            if (c == 500) begin
                start = 1'b1; len = 0; rate = 8'd255;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        #1;
        check("r0_no_reads", 64'(n0), 64'd0);
        check("r0_busy", 64'(busy), 64'd1);
        check("r0_done", 64'(done), 64'd0);

        // Abort an active run with an asynchronous reset
        #1 rst = 1'b1;
        #1;
        check("r0_abort_busy", 64'(busy), 64'd0);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 20; i++) push(16'h5000 + 16'(i ^ 3));
        @(negedge clk);
        start = 1'b1; len = 20; seed = 16'h5000; rate = 8'd255;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        check("pre_abort_progress", 64'(rcv_cnt != 0 && err), 64'd1);
        #1 rst = 1'b1;
        #1;
        check("abort_rd_en", 64'(rd_en), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_err", 64'(err), 64'd0);
        check("abort_counts", 64'({err_cnt, rcv_cnt}), 64'd0);
        check("abort_first", 64'({first_exp, first_got}), 64'd0);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("idle_after_abort", 64'({busy, done, rd_en}), 64'd0);

        check("no_read_while_empty", 64'(bad_reads), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end
endmodule
